// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bursts kept contiguous.
// Define FIFO_WR_ARB_TAG_EN to prepend the producer index to fifo_din.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ = 4,
    parameter int MAX_BURST = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
    output logic [NUM_REQ-1:0]            req_full,
    output logic                          fifo_wr,
`ifdef FIFO_WR_ARB_TAG_EN
    output logic [DATA_WIDTH+ID_W-1:0]    fifo_din,
`else
    output logic [DATA_WIDTH-1:0]         fifo_din,
`endif
    input  logic                          fifo_full,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t                r_state;
    logic [ID_W-1:0]       r_ptr, r_owner, r_grant;
    logic [7:0]            r_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  w_ready, w_found, w_elig, w_acc;
    logic [ID_W-1:0]       w_win, w_sel;
    logic [7:0]            w_cnt_nxt;
`ifdef FIFO_WR_ARB_TAG_EN
    logic [ID_W-1:0]       r_tag;
`endif

    function automatic logic [ID_W-1:0] f_rr(input logic [ID_W-1:0] p, input int k);
        return ID_W'((int'(p) + k) % NUM_REQ);
    endfunction

    // Scan from farthest to nearest so the producer right after ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_wr[f_rr(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win = f_rr(r_ptr, k);
            end
        end
    end

    assign w_ready   = !r_out_valid || !fifo_full;
    assign w_sel     = (r_state == BURST) ? r_owner : w_win;
    assign w_elig    = (r_state == BURST) ? req_wr[r_owner] : w_found;
    assign w_acc     = w_elig && w_ready;
    assign w_cnt_nxt = r_cnt + 8'd1;
    assign req_full  = (rst && w_acc) ? ~(NUM_REQ'(1) << w_sel) : '1;
    assign fifo_wr   = r_out_valid;
    assign grant_id  = r_grant;
    assign busy      = (r_state == BURST) || r_out_valid;
`ifdef FIFO_WR_ARB_TAG_EN
    assign fifo_din  = {r_tag, r_out_data};
`else
    assign fifo_din  = r_out_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ptr       <= ID_W'(NUM_REQ - 1);
            r_owner     <= '0;
            r_grant     <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
`ifdef FIFO_WR_ARB_TAG_EN
            r_tag       <= '0;
`endif
        end else begin
            if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_data  <= req_din[w_sel*DATA_WIDTH +: DATA_WIDTH];
`ifdef FIFO_WR_ARB_TAG_EN
                r_tag       <= w_sel;
`endif
            end else if (!fifo_full) begin
                r_out_valid <= 1'b0;
            end
            if (r_state == IDLE) begin
                if (w_acc) begin
                    r_grant <= w_sel;
                    if (MAX_BURST == 1) begin
                        r_ptr <= w_sel;
                    end else begin
                        r_state <= BURST;
                        r_owner <= w_sel;
                        r_cnt   <= 8'd1;
                    end
                end
            end else if (!req_wr[r_owner]) begin
                r_state <= IDLE;
                r_ptr   <= r_owner;
                r_cnt   <= '0;
            end else if (w_ready) begin
                if (w_cnt_nxt == 8'(MAX_BURST)) begin
                    r_state <= IDLE;
                    r_ptr   <= r_owner;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= w_cnt_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven arbitration vectors plus scoreboarded burst, backpressure and reset sequences.
module tb_fifo_wr_arbiter;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int IW = 2;
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int OW = DW + IW;
`else
    localparam int OW = DW;
`endif

    typedef struct {
        logic [N-1:0]  wr;
        logic [N-1:0]  exp_full;
        logic [IW-1:0] exp_gid;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_wr = '0;
    logic [N*DW-1:0] req_din = '0;
    logic [N-1:0]    req_full;
    logic            fifo_wr;
    logic [OW-1:0]   fifo_din;
    logic            fifo_full = 1'b0;
    logic [IW-1:0]   grant_id;
    logic            busy;

    vec_t            tbl [8];
    logic            auto_en = 1'b0;
    logic            t1_mon = 1'b0;
    logic [N-1:0]    full_zero = '0;
    logic [N-1:0]    tbl_wr = '0;
    logic [N*DW-1:0] tbl_din = '0;
    logic [N-1:0]    acc_s = '0;
    logic [DW-1:0]   pbuf [N][32];
    int              phead [N] = '{default: 0};
    int              ptail [N] = '{default: 0};
    int              cyc = 0, n_out = 0, n_chk = 0, n_fail = 0;
    int              out_cyc [64];
    logic [OW-1:0]   exp_q [$];

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req_wr(req_wr), .req_din(req_din), .req_full(req_full),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_full(fifo_full),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] ew(input int p, input logic [DW-1:0] d);
        return OW'({IW'(p), d});
    endfunction

    task automatic load(input int p, input logic [DW-1:0] d);
        pbuf[p][ptail[p]] = d;
        ptail[p]++;
        exp_q.push_back(ew(p, d));
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 64'(exp_q.size()), 0);
    endtask

    task automatic wait_out(input int target);
        int k = 0;
        while (n_out < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("wait_out", 64'(n_out), 64'(target));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Producers pop on the handshake sampled at the previous falling edge.
    always @(posedge clk) begin
        #1;
        if (auto_en) begin
            for (int i = 0; i < N; i++) begin
                if (acc_s[i]) phead[i]++;
                req_wr[i] = phead[i] < ptail[i];
                req_din[i*DW +: DW] = pbuf[i][phead[i]];
            end
        end else begin
            req_wr = tbl_wr;
            req_din = tbl_din;
        end
    end

    always @(negedge clk) begin
        acc_s = req_wr & ~req_full;
        if (t1_mon) full_zero = full_zero | (~req_full & 4'b1101);
        if (rst && fifo_wr && !fifo_full) begin
            if (n_out < 64) out_cyc[n_out] = cyc;
            n_out++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none", fifo_din);
            end else begin
                chk("fifo_din", 64'(fifo_din), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int b, c0, w;
        logic [OW-1:0] held;
        tbl[0] = '{4'b1111, 4'b1110, 2'd0};
        tbl[1] = '{4'b1111, 4'b1101, 2'd1};
        tbl[2] = '{4'b0001, 4'b1110, 2'd0};
        tbl[3] = '{4'b1001, 4'b0111, 2'd3};
        tbl[4] = '{4'b0000, 4'b1111, 2'd3};
        tbl[5] = '{4'b0110, 4'b1101, 2'd1};
        tbl[6] = '{4'b0101, 4'b1011, 2'd2};
        tbl[7] = '{4'b0101, 4'b1110, 2'd0};

        repeat (2) @(negedge clk);
        chk("rst_full", 64'(req_full), 64'hF);
        chk("rst_wr", 64'(fifo_wr), 0);
        chk("rst_din", 64'(fifo_din), 0);
        chk("rst_gid", 64'(grant_id), 0);
        chk("rst_busy", 64'(busy), 0);
        rst = 1'b1;

        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            tbl_wr = tbl[r].wr;
            for (int i = 0; i < N; i++) tbl_din[i*DW +: DW] = DW'(32'h100 * r + i);
            w = -1;
            for (int i = 0; i < N; i++) if (!tbl[r].exp_full[i]) w = i;
            if (w >= 0) exp_q.push_back(ew(w, DW'(32'h100 * r + w)));
            @(negedge clk);
            chk("tbl_full", 64'(req_full), 64'(tbl[r].exp_full));
            tbl_wr = '0;
            @(negedge clk);
            chk("tbl_gid", 64'(grant_id), 64'(tbl[r].exp_gid));
        end
        wait_drain("tbl_drain");
        @(negedge clk);
        auto_en = 1'b1;

        do_reset();
        @(negedge clk);
        b = n_out;
        c0 = cyc;
        t1_mon = 1'b1;
        load(1, 32'h5A);
        load(1, 32'hF6);
        load(1, 32'h09);
        wait_drain("t1_drain");
        t1_mon = 1'b0;
        chk("t1_others_full", 64'(full_zero), 0);
        chk("t1_latency", 64'(out_cyc[b]), 64'(c0 + 2));
        chk("t1_contig", 64'(out_cyc[b+2] - out_cyc[b]), 2);

        do_reset();
        @(negedge clk);
        b = n_out;
        for (int i = 0; i < 8; i++) begin
            pbuf[0][ptail[0]] = DW'(i);
            ptail[0]++;
            pbuf[2][ptail[2]] = DW'(32'h20 + i);
            ptail[2]++;
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(ew(0, DW'(i)));
        for (int i = 0; i < 4; i++) exp_q.push_back(ew(2, DW'(32'h20 + i)));
        for (int i = 4; i < 8; i++) exp_q.push_back(ew(0, DW'(i)));
        for (int i = 4; i < 8; i++) exp_q.push_back(ew(2, DW'(32'h20 + i)));
        wait_drain("t2_drain");
        chk("t2_contig", 64'(out_cyc[b+15] - out_cyc[b]), 15);

        @(negedge clk);
        b = n_out;
        load(3, 32'hC4);
        load(3, 32'h81);
        load(0, 32'h11);
        load(0, 32'h12);
        wait_drain("t3_drain");
        chk("t3_b2b", 64'(out_cyc[b+1] - out_cyc[b]), 1);
        chk("t3_bubble", 64'(out_cyc[b+2] - out_cyc[b+1]), 2);
        chk("t3_gid", 64'(grant_id), 0);

        @(negedge clk);
        b = n_out;
        for (int i = 0; i < 4; i++) load(1, DW'(32'h40 + i));
        load(2, 32'h50);
        load(2, 32'h51);
        wait_out(b + 1);
        @(posedge clk);
        #1 fifo_full = 1'b1;
        held = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) held = fifo_din;
            else chk("t4_din_hold", 64'(fifo_din), 64'(held));
            chk("t4_wr_hold", 64'(fifo_wr), 1);
            chk("t4_owner_full", 64'(req_full[1]), 1);
        end
        @(posedge clk);
        #1 fifo_full = 1'b0;
        wait_drain("t4_drain");

        @(negedge clk);
        b = n_out;
        for (int i = 0; i < 4; i++) load(1, DW'(32'h60 + i));
        wait_out(b + 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_wr_async", 64'(fifo_wr), 0);
        chk("t5_full_async", 64'(req_full), 64'hF);
        chk("t5_din_async", 64'(fifo_din), 0);
        chk("t5_busy_async", 64'(busy), 0);
        chk("t5_gid_async", 64'(grant_id), 0);
        @(posedge clk);
        #2;
        exp_q.delete();
        for (int i = 0; i < N; i++) ptail[i] = phead[i];
        for (int i = 0; i < N; i++) load(i, DW'(32'h70 + i));
        repeat (2) @(negedge clk);
        chk("t5_full_in_rst", 64'(req_full), 64'hF);
        rst = 1'b1;
        wait_drain("t5_drain");

        @(negedge clk);
        load(2, 32'hA0);
        w = 0;
        while (!fifo_wr && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("t6_tag", 64'(fifo_din), 64'(OW'(34'h2_000000A0)));
        wait_drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
